// File: rtl/output_unloader.sv
// Purpose: captures a wide result word and serializes it LS word first onto a valid/ready stream.
// Latency: first word is valid one cycle after load; done pulses one cycle after the final transfer.
// Backpressure: out_word/word_idx hold while out_ready=0; loads arriving mid-drain are dropped and flagged.
module output_unloader #(
    parameter  int DATA_W = 256,
    parameter  int WORD_W = 16,
    localparam int NWORDS = DATA_W / WORD_W,
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  word_idx,
    output logic              overflow,
    input  logic              clr_ovf
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   shadow_q,    shadow_d;
    logic [WORD_W-1:0]   out_word_q,  out_word_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic [IDX_W-1:0]    word_idx_q,  word_idx_d;
    logic                overflow_q,  overflow_d;
    logic [IDX_W-1:0]    nxt_idx;
    logic                ovf_set;

    // Next-state logic: capture in IDLE, advance one word per accepted transfer in SEND.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        word_idx_d  = word_idx_q;
        ovf_set     = 1'b0;
        nxt_idx     = word_idx_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d     = ST_SEND;
                    shadow_d    = load_data;
                    word_idx_d  = '0;
                    out_word_d  = load_data[WORD_W-1:0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_SEND: begin
                // The shadow register is owned by the current drain, so a new result is lost.
                ovf_set = load;
                if (out_ready) begin
                    if (word_idx_q == IDX_W'(NWORDS - 1)) begin
                        state_d     = ST_IDLE;
                        word_idx_d  = '0;
                        out_word_d  = '0;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        word_idx_d = nxt_idx;
                        out_word_d = shadow_q[int'(nxt_idx) * WORD_W +: WORD_W];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A dropped load in the same cycle as a clear still leaves the flag set.
        overflow_d = ovf_set | (overflow_q & ~clr_ovf);
    end

    // State and registered outputs, cleared asynchronously so a reset abandons any drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            word_idx_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            word_idx_q  <= word_idx_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign word_idx  = word_idx_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_unloader.sv
// Bench for output_unloader: directed scenarios plus a randomized run against a word-queue model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every comparison bumps total; every failing one bumps bad and prints a FAIL line.
module tb_output_unloader;

    localparam int DATA_W = 256;
    localparam int WORD_W = 16;
    localparam int NWORDS = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [3:0]        word_idx;
    logic              overflow;
    logic              clr_ovf;

    int total = 0;
    int bad   = 0;

    output_unloader #(.DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .word_idx  (word_idx),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Starts a drain of d with the given ready level; returns at the first sample after capture.
    task automatic start_load(input logic [DATA_W-1:0] d, input logic rdy);
        @(negedge clk);
        load      = 1'b1;
        load_data = d;
        out_ready = rdy;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        start_load({16{16'h1234}}, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL reset_pre_busy: got %b want 1", busy);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, done, overflow, word_idx, out_word} !== 24'h0) begin
            bad++;
            $display("FAIL reset_async: got v=%b b=%b d=%b o=%b idx=%0d w=%h want all 0",
                     out_valid, busy, done, overflow, word_idx, out_word);
        end
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, busy, done, overflow, word_idx, out_word} !== 24'h0) begin
                bad++;
                $display("FAIL reset_idle c=%0d: got v=%b b=%b d=%b o=%b idx=%0d w=%h want all 0",
                         c, out_valid, busy, done, overflow, word_idx, out_word);
            end
        end
    endtask

    task automatic test_full_drain();
        start_load({16{16'h5555}}, 1'b1);
        for (int k = 0; k < NWORDS; k++) begin
            total++;
            if ({out_valid, busy, done, word_idx, out_word} !== {1'b1, 1'b1, 1'b0, 4'(k), 16'h5555}) begin
                bad++;
                $display("FAIL drain k=%0d: got v=%b b=%b d=%b idx=%0d w=%h want v=1 b=1 d=0 idx=%0d w=5555",
                         k, out_valid, busy, done, word_idx, out_word, k);
            end
            @(negedge clk);
        end
        total++;
        if ({out_valid, busy, done, word_idx} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL drain_done: got v=%b b=%b d=%b idx=%0d want v=0 b=0 d=1 idx=0",
                     out_valid, busy, done, word_idx);
        end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++; $display("FAIL drain_done_width: got d=%b b=%b want 0 0", done, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d;
        logic rdy;
        int idx_exp, xfers, dones;
        for (int k = 0; k < NWORDS; k++) d[k*16 +: 16] = {4'h0, 4'(k), 4'h0, 4'(k)};
        start_load(d, 1'b0);
        rdy = 1'b0; idx_exp = 0; xfers = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) begin
                total++;
                if (idx_exp >= NWORDS) begin
                    bad++; $display("FAIL bp_extra_word c=%0d: got idx=%0d w=%h want no word", c, word_idx, out_word);
                end else if (out_word !== d[idx_exp*16 +: 16] || word_idx !== 4'(idx_exp)) begin
                    bad++;
                    $display("FAIL bp_word c=%0d: got idx=%0d w=%h want idx=%0d w=%h",
                             c, word_idx, out_word, idx_exp, d[idx_exp*16 +: 16]);
                end
            end
            rdy = ~rdy;
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin xfers++; idx_exp++; end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (xfers != NWORDS || dones != 1) begin
            bad++; $display("FAIL bp_count: got xfers=%0d dones=%0d want 16 1", xfers, dones);
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        int seen;
        bit injected;
        a = {16{16'hAAAA}};
        b = {16{16'h5555}};
        seen = 0; injected = 0;
        start_load(a, 1'b1);
        for (int c = 0; c < 25; c++) begin
            load = 1'b0;
            total++;
            if (overflow !== injected) begin
                bad++; $display("FAIL ovf_flag c=%0d: got %b want %b", c, overflow, injected);
            end
            if (out_valid === 1'b1) begin
                total++;
                if (out_word !== 16'hAAAA || word_idx !== 4'(seen)) begin
                    bad++;
                    $display("FAIL ovf_word c=%0d: got idx=%0d w=%h want idx=%0d w=aaaa", c, word_idx, out_word, seen);
                end
                if (word_idx === 4'd3 && !injected) begin
                    load = 1'b1; load_data = b; injected = 1;
                end
                seen++;
            end
            @(negedge clk);
        end
        total++;
        if (seen != NWORDS) begin
            bad++; $display("FAIL ovf_count: got %0d words want 16", seen);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] cur;
        int ph, k, dones;
        bit expect_start;
        x = rand_data(); y = rand_data();
        ph = 0; k = 0; dones = 0; expect_start = 0;
        start_load(x, 1'b1);
        for (int c = 0; c < 45; c++) begin
            load = 1'b0;
            cur = (ph == 0) ? x : y;
            if (expect_start) begin
                total++;
                if ({out_valid, word_idx, out_word, overflow} !== {1'b1, 4'd0, y[15:0], 1'b0}) begin
                    bad++;
                    $display("FAIL b2b_start: got v=%b idx=%0d w=%h o=%b want v=1 idx=0 w=%h o=0",
                             out_valid, word_idx, out_word, overflow, y[15:0]);
                end
                expect_start = 0;
            end
            if (out_valid === 1'b1) begin
                total++;
                if (k >= NWORDS || out_word !== cur[k*16 +: 16] || word_idx !== 4'(k) || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_word ph=%0d k=%0d: got idx=%0d w=%h o=%b", ph, k, word_idx, out_word, overflow);
                end
                k++;
            end
            if (done === 1'b1) begin
                dones++;
                if (ph == 0) begin
                    load = 1'b1; load_data = y; ph = 1; k = 0; expect_start = 1;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (dones != 2 || ph != 1 || k != NWORDS) begin
            bad++; $display("FAIL b2b_count: got dones=%0d ph=%0d k=%0d want 2 1 16", dones, ph, k);
        end
    endtask

    task automatic test_mid_drain_reset();
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        int c, dones, k;
        x = rand_data(); y = rand_data();
        start_load(x, 1'b1);
        c = 0;
        while (!(out_valid === 1'b1 && word_idx === 4'd7) && c < 20) begin
            @(negedge clk); c++;
        end
        total++;
        if (c >= 20) begin
            bad++; $display("FAIL mdr_reach7: got idx=%0d want 7 within 20 cycles", word_idx);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, done, word_idx} !== 7'h0) begin
            bad++;
            $display("FAIL mdr_async: got v=%b b=%b d=%b idx=%0d want 0", out_valid, busy, done, word_idx);
        end
        #2 reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL mdr_no_done: got %0d active cycles want 0", dones);
        end
        start_load(y, 1'b1);
        k = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) begin
                total++;
                if (k >= NWORDS || out_word !== y[k*16 +: 16] || word_idx !== 4'(k)) begin
                    bad++; $display("FAIL mdr_word k=%0d: got idx=%0d w=%h", k, word_idx, out_word);
                end
                k++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (k != NWORDS || dones != 1) begin
            bad++; $display("FAIL mdr_count: got words=%0d dones=%0d want 16 1", k, dones);
        end
    endtask

    // Randomized traffic against a model holding the accepted result and a count of words sent.
    task automatic test_random();
        logic [DATA_W-1:0] m_data;
        logic [DATA_W-1:0] d;
        int   m_sent;
        bit   m_busy, m_done, m_ovf, ld, rdy, clr;
        @(negedge clk);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        m_data = '0; m_sent = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== m_busy || busy !== m_busy || done !== m_done || overflow !== m_ovf ||
                word_idx !== 4'(m_busy ? m_sent : 0) ||
                (m_busy && out_word !== m_data[m_sent*16 +: 16])) begin
                bad++;
                $display("FAIL rand c=%0d: got v=%b b=%b d=%b o=%b idx=%0d w=%h want v=%b d=%b o=%b idx=%0d w=%h",
                         c, out_valid, busy, done, overflow, word_idx, out_word,
                         m_busy, m_done, m_ovf, m_busy ? m_sent : 0, m_data[m_sent*16 +: 16]);
            end
            ld  = ($urandom_range(0, 5) == 0);
            rdy = $urandom_range(0, 1);
            clr = ($urandom_range(0, 9) == 0);
            d   = rand_data();
            load = ld; load_data = d; out_ready = rdy; clr_ovf = clr;
            m_done = 0;
            if (m_busy) begin
                if (ld) m_ovf = 1;
                else if (clr) m_ovf = 0;
                if (rdy) begin
                    m_sent++;
                    if (m_sent == NWORDS) begin
                        m_busy = 0; m_sent = 0; m_done = 1;
                    end
                end
            end else begin
                if (clr) m_ovf = 0;
                if (ld) begin
                    m_busy = 1; m_data = d; m_sent = 0;
                end
            end
        end
        @(negedge clk);
        load = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_full_drain();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_mid_drain_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within 400000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
